// File: rtl/seq_detect_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_scan_ctrl
// Brief    : Frame scan controller that serialises words MSB-first into a bit-serial
//            sequence detector and counts qualified hits per frame.
//            Optional abort input enabled by defining SEQ_SCAN_ABORT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seq_detect_scan_ctrl #(
    parameter int WORD_W  = 8,
    parameter int CNT_W   = 16,
    parameter int DET_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
`ifdef SEQ_SCAN_ABORT_EN
    input  logic              abort,
`endif
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_last,
    input  logic [CNT_W-1:0]  thresh,
    output logic              det_clr,
    output logic              det_en,
    output logic              det_bit,
    input  logic              det_hit,
    output logic              busy,
    output logic              frame_done,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              thresh_hit
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLR   = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    localparam int BIT_W = $clog2(WORD_W);
    localparam int DRN_W = $clog2(DET_LAT + 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(WORD_W - 1);
    localparam logic [DRN_W-1:0] LAST_DRN  = DRN_W'(DET_LAT - 1);

    logic [2:0]         state;
    logic [2:0]         state_nxt;
    logic [WORD_W-1:0]  shreg;
    logic               last_q;
    logic [BIT_W-1:0]   bit_cnt;
    logic [DRN_W-1:0]   drain_cnt;
    logic [DET_LAT-1:0] en_dly;
    logic               accept;
    logic               hit_q;

    assign accept = s_valid & s_ready;
    // A hit is only genuine if it lines up with a strobe issued DET_LAT cycles earlier.
    assign hit_q  = det_hit & en_dly[DET_LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CLR;
            CLR:     state_nxt = SHIFT;
            SHIFT:   if (bit_cnt == LAST_BIT) state_nxt = last_q ? DRAIN : WAIT;
            WAIT:    if (accept) state_nxt = SHIFT;
            DRAIN:   if (drain_cnt == LAST_DRN) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
`ifdef SEQ_SCAN_ABORT_EN
        if (abort && (state != IDLE) && (state != DONE)) begin
            state_nxt = DONE;
        end
`endif
    end

    always_comb begin
        s_ready    = ~rst & ((state == IDLE) | (state == WAIT));
        det_clr    = (state == CLR);
        det_en     = (state == SHIFT);
`ifdef SEQ_SCAN_ABORT_EN
        det_en     = (state == SHIFT) & ~abort;
`endif
        det_bit    = det_en & shreg[WORD_W-1];
        busy       = (state != IDLE);
        frame_done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg      <= '0;
            last_q     <= 1'b0;
            bit_cnt    <= '0;
            drain_cnt  <= '0;
            en_dly     <= '0;
            match_cnt  <= '0;
            thresh_hit <= 1'b0;
        end else begin
            if (accept) begin
                shreg  <= s_data;
                last_q <= s_last;
            end else if (state == SHIFT) begin
                shreg  <= shreg << 1;
            end

            bit_cnt   <= (state == SHIFT) ? bit_cnt + 1'b1 : '0;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;

            en_dly[0] <= det_en;
            for (int i = 1; i < DET_LAT; i++) begin
                en_dly[i] <= en_dly[i-1];
            end

            if (state == CLR) begin
                match_cnt  <= '0;
                thresh_hit <= 1'b0;
            end else begin
                if (hit_q && (match_cnt != {CNT_W{1'b1}})) begin
                    match_cnt <= match_cnt + 1'b1;
                end
                if ((thresh != '0) && (match_cnt >= thresh)) begin
                    thresh_hit <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detect_scan_ctrl
// Brief    : Directed bench with an overlapping "1101" detector model (latency 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detect_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_last;
    logic [7:0] thresh;
    logic       det_clr;
    logic       det_en;
    logic       det_bit;
    logic       det_hit;
    logic       busy;
    logic       frame_done;
    logic [7:0] match_cnt;
    logic       thresh_hit;

    int tests_run    = 0;
    int tests_failed = 0;

    seq_detect_scan_ctrl #(.WORD_W(8), .CNT_W(8), .DET_LAT(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .thresh     (thresh),
        .det_clr    (det_clr),
        .det_en     (det_en),
        .det_bit    (det_bit),
        .det_hit    (det_hit),
        .busy       (busy),
        .frame_done (frame_done),
        .match_cnt  (match_cnt),
        .thresh_hit (thresh_hit)
    );

    always #5 clk = ~clk;

    // Detector model: registered overlapping "1101" match, state held when det_en=0.
    logic [3:0] hist;
    logic       hit_reg;
    logic       force_hit;
    always @(posedge clk) begin
        if (rst || det_clr) begin
            hist    <= '0;
            hit_reg <= 1'b0;
        end else if (det_en) begin
            hist    <= {hist[2:0], det_bit};
            hit_reg <= ({hist[2:0], det_bit} == 4'b1101);
        end else begin
            hit_reg <= 1'b0;
        end
    end
    assign det_hit = force_hit | hit_reg;

    int          clr_cnt  = 0;
    int          en_cnt   = 0;
    int          done_cnt = 0;
    int          bad_bit  = 0;
    logic [31:0] bits     = '0;
    always @(negedge clk) begin
        if (det_clr) clr_cnt++;
        if (det_en) begin
            en_cnt++;
            bits = {bits[30:0], det_bit};
        end else if (det_bit) begin
            bad_bit++;
        end
        if (frame_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] d, input logic l);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!s_ready && n < 50) begin
            tick();
            n++;
        end
        if (!s_ready) begin
            tests_run++;
            tests_failed++;
            $display("FAIL accept_timeout: got s_ready 0 expected 1");
        end else begin
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'($urandom);
    endtask

    task automatic wait_done();
        int start = done_cnt;
        int n     = 0;
        while (done_cnt == start && n < 200) begin
            tick();
            n++;
        end
        if (done_cnt == start) begin
            tests_run++;
            tests_failed++;
            $display("FAIL done_timeout: got no frame_done expected one");
        end
    endtask

    int c0, e0, d0;

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        thresh = '0; force_hit = 1'b0;

        // Reset behaviour
        tick(); tick();
        check("rst_outs", {25'd0, s_ready, busy, det_en, det_clr, det_bit, frame_done, thresh_hit}, 0);
        check("rst_cnt", match_cnt, 0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", s_ready, 1);
        check("post_rst_busy", busy, 0);

        // Single-word frame
        c0 = clr_cnt; e0 = en_cnt; d0 = done_cnt;
        send_word(8'b1101_1010, 1'b1);
        wait_done();
        repeat (3) tick();
        check("w1_clr", clr_cnt - c0, 1);
        check("w1_en", en_cnt - e0, 8);
        check("w1_bits", {24'd0, bits[7:0]}, 32'hDA);
        check("w1_match", match_cnt, 2);
        check("w1_done", done_cnt - d0, 1);

        // Two-word frame with a gap in WAIT
        c0 = clr_cnt; e0 = en_cnt;
        send_word(8'hB0, 1'b0);
        repeat (9) tick();
        check("gap_en_a", en_cnt - e0, 8);
        repeat (3) tick();
        check("gap_en_b", en_cnt - e0, 8);
        check("gap_wait", {30'd0, busy, s_ready}, 3);
        send_word(8'h00, 1'b1);
        wait_done();
        check("w2_clr", clr_cnt - c0, 1);
        check("w2_en", en_cnt - e0, 16);
        check("w2_match", match_cnt, 0);

        // Threshold flag
        thresh = 8'd2;
        send_word(8'hDB, 1'b1);
        wait_done();
        check("th_match", match_cnt, 2);
        check("th_set", thresh_hit, 1);
        repeat (2) tick();
        check("th_sticky", thresh_hit, 1);
        thresh = 8'd0;
        send_word(8'hDB, 1'b1);
        check("th_hold_clr", thresh_hit, 1);
        tick();
        check("th_clr", thresh_hit, 0);
        wait_done();
        check("th0_match", match_cnt, 2);
        check("th0_flag", thresh_hit, 0);

        // Forced hits: only strobe-aligned cycles count, WAIT is ignored
        force_hit = 1'b1;
        send_word(8'h00, 1'b0);
        repeat (14) tick();
        send_word(8'h00, 1'b1);
        wait_done();
        repeat (4) tick();
        check("qual_match", match_cnt, 16);

        // Saturation
        for (int i = 0; i < 600; i++) begin
            send_word(8'(i), (i == 599));
        end
        wait_done();
        check("sat_match", match_cnt, 255);
        force_hit = 1'b0;

        // Reset mid-SHIFT then a normal frame
        send_word(8'hDA, 1'b1);
        repeat (4) tick();
        check("mid_busy", busy, 1);
        rst = 1'b1;
        tick();
        check("mid_rst_outs", {28'd0, busy, det_en, s_ready, frame_done}, 0);
        check("mid_rst_cnt", match_cnt, 0);
        rst = 1'b0;
        tick();
        check("mid_rel_ready", s_ready, 1);
        e0 = en_cnt;
        send_word(8'hDA, 1'b1);
        wait_done();
        check("re_en", en_cnt - e0, 8);
        check("re_match", match_cnt, 2);
        check("bit_idle_zero", bad_bit, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
